// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on memory readiness, traps unknown opcodes and counts retired instructions.
module multicycle_control #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OP_W-1:0]  Op_i,
  input  logic             Zero_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             IRWrite_o,
  output logic             IorD_o,
  output logic             Memory_read_o,
  output logic             Memory_write_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  state_t            state_q, next_state;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              retire;
  logic              illegal;
  logic              active;

  // Unconditional per-state controls; the ready/zero-qualified strobes are added at the ports.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 2'b01; end
      DECODE: begin c.alu_src_b = 2'b11; c.alu_op = 2'b01; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b01; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:   c.alu_src_a = 1'b1;
      RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b11; c.pc_source = 2'b01; end
      IEXEC:  begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (op == OP_ORI) ? 2'b10 : 2'b01;
      end
      IWB:    c.reg_write = 1'b1;
      JUMP:   begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    next_state = state_q;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH:  if (mem_ready_i) next_state = DECODE;
      DECODE: begin
        case (Op_i)
          OP_R:           next_state = EXEC;
          OP_LW, OP_SW:   next_state = MEMADR;
          OP_ADDI, OP_ORI: next_state = IEXEC;
          OP_BEQ:         next_state = BRANCH;
          OP_J:           next_state = JUMP;
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: next_state = (Op_i == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready_i) next_state = MEMWB;
      MEMWR:  if (mem_ready_i) begin next_state = FETCH; retire = 1'b1; end
      EXEC:   next_state = RWB;
      IEXEC:  next_state = IWB;
      MEMWB, RWB, BRANCH, IWB, JUMP: begin
        next_state = FETCH;
        retire     = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // Controls are registered from the next state so they are glitch-free at the start of each state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      ctrl_q  <= decode_ctrl(FETCH, '0);
      cnt_q   <= '0;
    end else begin
      state_q <= next_state;
      ctrl_q  <= decode_ctrl(next_state, Op_i);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Reset silences every output immediately, as do the unreachable encodings.
  assign active = !rst_i && (state_q <= JUMP);

  assign PCWrite_o      = active && (ctrl_q.pc_write
                                     || (state_q == FETCH && mem_ready_i)
                                     || (state_q == BRANCH && Zero_i));
  assign IRWrite_o      = active && state_q == FETCH && mem_ready_i;
  assign IorD_o         = active && ctrl_q.iord;
  assign Memory_read_o  = active && ctrl_q.mem_read;
  assign Memory_write_o = active && ctrl_q.mem_write;
  assign RegDst_o       = active && ctrl_q.reg_dst;
  assign RegWrite_o     = active && ctrl_q.reg_write;
  assign MemtoReg_o     = active && ctrl_q.mem_to_reg;
  assign ALUSrcA_o      = active && ctrl_q.alu_src_a;
  assign ALUSrcB_o      = {2{active}} & ctrl_q.alu_src_b;
  assign ALUOp_o        = {2{active}} & ctrl_q.alu_op;
  assign PCSource_o     = {2{active}} & ctrl_q.pc_source;
  assign illegal_o      = active && illegal;
  assign state_o        = state_q;
  assign instr_count_o  = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of per-instruction state sequences with a
// scoreboard of expected per-cycle outputs, plus reset-abort and counter-wrap sequences.
module tb_multicycle_control;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       ready;

  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [15:0] count;

  logic        pc_write_b, ir_write_b, iord_b, mem_read_b, mem_write_b, reg_dst_b, reg_write_b, mem_to_reg_b, alu_src_a_b, illegal_b;
  logic [1:0]  alu_src_b_b, alu_op_b, pc_source_b;
  logic [3:0]  state_b;
  logic [1:0]  count_b;

  wire [15:0] outs   = {pc_write, ir_write, iord, mem_read, mem_write, reg_dst, reg_write, mem_to_reg,
                        alu_src_a, alu_src_b, alu_op, pc_source, illegal};
  wire [15:0] outs_b = {pc_write_b, ir_write_b, iord_b, mem_read_b, mem_write_b, reg_dst_b, reg_write_b, mem_to_reg_b,
                        alu_src_a_b, alu_src_b_b, alu_op_b, pc_source_b, illegal_b};

  multicycle_control #(.OP_W(6), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .Zero_i(zero), .mem_ready_i(ready),
    .PCWrite_o(pc_write), .IRWrite_o(ir_write), .IorD_o(iord), .Memory_read_o(mem_read),
    .Memory_write_o(mem_write), .RegDst_o(reg_dst), .RegWrite_o(reg_write), .MemtoReg_o(mem_to_reg),
    .ALUSrcA_o(alu_src_a), .ALUSrcB_o(alu_src_b), .ALUOp_o(alu_op), .PCSource_o(pc_source),
    .illegal_o(illegal), .state_o(state), .instr_count_o(count)
  );

  multicycle_control #(.OP_W(6), .CNT_W(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .Op_i(op), .Zero_i(zero), .mem_ready_i(ready),
    .PCWrite_o(pc_write_b), .IRWrite_o(ir_write_b), .IorD_o(iord_b), .Memory_read_o(mem_read_b),
    .Memory_write_o(mem_write_b), .RegDst_o(reg_dst_b), .RegWrite_o(reg_write_b), .MemtoReg_o(mem_to_reg_b),
    .ALUSrcA_o(alu_src_a_b), .ALUSrcB_o(alu_src_b_b), .ALUOp_o(alu_op_b), .PCSource_o(pc_source_b),
    .illegal_o(illegal_b), .state_o(state_b), .instr_count_o(count_b)
  );

  always #HALF clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] outs;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string           name;
    logic [5:0]      op;
    logic            zero;
    int              len;
    logic [0:11][3:0] seq;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[10];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_count = '0;
  int          exp_small[5] = '{1, 2, 3, 0, 1};

  // Output bundle each state should present, straight from the state/output table.
  function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic [5:0] o, input logic z, input logic rdy);
    logic pw, irw, io, mr, mw, rd, rw, m2r, sa, ill;
    logic [1:0] sb, aop, pcs;
    {pw, irw, io, mr, mw, rd, rw, m2r, sa, ill} = '0;
    {sb, aop, pcs} = '0;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; aop = 2'b01; pw = rdy; irw = rdy; end
      4'd1:  begin
        sb = 2'b11; aop = 2'b01;
        ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101, 6'b000100, 6'b000010});
      end
      4'd2:  begin sa = 1; sb = 2'b10; aop = 2'b01; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; io = 1; end
      4'd6:  sa = 1;
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b11; pcs = 2'b01; pw = z; end
      4'd9:  begin sa = 1; sb = 2'b10; aop = (o == 6'b001101) ? 2'b10 : 2'b01; end
      4'd10: rw = 1;
      4'd11: begin pcs = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, irw, io, mr, mw, rd, rw, m2r, sa, sb, aop, pcs, ill};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [5:0] o, input logic z, input logic rdy);
    exp_t e;
    op    = o;
    zero  = z;
    ready = rdy;
    e.st   = st;
    e.outs = rst ? 16'h0000 : exp_outs(st, o, z, rdy);
    e.cnt  = exp_count;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: scoreboard empty, got state %0d, expected an entry", tag, state);
      return;
    end
    e = sb_q.pop_front();
    check({tag, " state"},      16'(state),   16'(e.st));
    check({tag, " outputs"},    outs,         e.outs);
    check({tag, " count"},      count,        e.cnt);
    check({tag, " state2"},     16'(state_b), 16'(e.st));
    check({tag, " outputs2"},   outs_b,       e.outs);
    check({tag, " count2"},     16'(count_b), 16'(e.cnt[1:0]));
  endtask

  task automatic doCycle(input logic [3:0] st, input logic [5:0] o, input logic z, input logic rdy, input string tag);
    applyStimulus(st, o, z, rdy);
    #2;
    checkOutput(tag);
    if (st inside {4'd4, 4'd7, 4'd8, 4'd10, 4'd11} || (st == 4'd5 && rdy)) exp_count++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"add",     6'b000000, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 32'd0}};
    vecs[1] = '{"lw_wait", 6'b100011, 1'b0, 8, {4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 16'd0}};
    vecs[2] = '{"sw_wait", 6'b101011, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 28'd0}};
    vecs[3] = '{"addi",    6'b001000, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd10, 32'd0}};
    vecs[4] = '{"ori",     6'b001101, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd10, 32'd0}};
    vecs[5] = '{"beq_z1",  6'b000100, 1'b1, 3, {4'd0, 4'd1, 4'd8, 36'd0}};
    vecs[6] = '{"beq_z0",  6'b000100, 1'b0, 3, {4'd0, 4'd1, 4'd8, 36'd0}};
    vecs[7] = '{"j",       6'b000010, 1'b1, 3, {4'd0, 4'd1, 4'd11, 36'd0}};
    vecs[8] = '{"illegal", 6'b111111, 1'b0, 2, {4'd0, 4'd1, 40'd0}};
    vecs[9] = '{"r_fwait", 6'b000000, 1'b1, 6, {4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7, 24'd0}};

    rst   = 1'b1;
    op    = '0;
    zero  = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(4'd0, 6'b000000, 1'b1, 1'b1);
    #2;
    checkOutput("reset");
    rst   = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        logic [3:0] st;
        logic       rdy;
        st  = vecs[v].seq[i];
        rdy = !((i + 1 < vecs[v].len) && (vecs[v].seq[i+1] == st));
        doCycle(st, vecs[v].op, vecs[v].zero, rdy, $sformatf("%s c%0d", vecs[v].name, i));
      end
    end

    // Reset lands while a store is waiting on memory.
    doCycle(4'd0, 6'b101011, 1'b0, 1'b1, "abort c0");
    doCycle(4'd1, 6'b101011, 1'b0, 1'b1, "abort c1");
    doCycle(4'd2, 6'b101011, 1'b0, 1'b1, "abort c2");
    applyStimulus(4'd5, 6'b101011, 1'b0, 1'b0);
    #2;
    checkOutput("abort memwr");
    rst       = 1'b1;
    exp_count = '0;
    #1;
    applyStimulus(4'd0, 6'b101011, 1'b0, 1'b1);
    #1;
    checkOutput("abort in reset");
    @(posedge clk);
    #1;
    applyStimulus(4'd0, 6'b101011, 1'b0, 1'b1);
    #2;
    checkOutput("abort held");
    rst   = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++) begin
      doCycle(4'd0,  6'b001000, 1'b0, 1'b1, $sformatf("wrap%0d c0", k));
      doCycle(4'd1,  6'b001000, 1'b0, 1'b1, $sformatf("wrap%0d c1", k));
      doCycle(4'd9,  6'b001000, 1'b0, 1'b1, $sformatf("wrap%0d c2", k));
      doCycle(4'd10, 6'b001000, 1'b0, 1'b1, $sformatf("wrap%0d c3", k));
      check($sformatf("small count after addi %0d", k), 16'(count_b), 16'(exp_small[k]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
